fp_norm_round: RTL and testbench
================================

# fp_norm_round

Normalize-and-round back end of the single-precision multiplier pipeline. Consumes the registered {sign, exponent-sum, 48-bit significand product} triple from the multiply stage through a valid/ready handshake. Produces a packed IEEE-754 binary32 result with overflow/underflow flags. Internally two pipeline stages: normalize, then round/pack. Full-throughput with backpressure.

## Interface
- `ROUND_EN`, default 1: 1 = round-to-nearest-even; 0 = truncate (guard/sticky ignored).
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `in_valid` input, 1 bit: input triple valid.
- `in_ready` output, 1 bit: block can accept this cycle.
- `in_sign` input, 1 bit: product sign (sign_a ^ sign_b).
- `in_exp` input, 9 bits: unsigned sum of biased exponents (exp_a + exp_b), range 0..510.
- `in_prod` input, 48 bits: 24x24 significand product with hidden bits; leading one at bit 47 or bit 46, or all-zero.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: downstream accepts.
- `out_result` output, 32 bits: {sign, exp[7:0], frac[22:0]}.
- `out_ovf` output, 1 bit: overflow to infinity, qualified by out_valid.
- `out_unf` output, 1 bit: underflow flushed to zero, qualified by out_valid.

## Operation
- Transfer occurs on a rising clk when valid && ready at that interface.
- **Stage 1, normalize.** Registers s1_valid, sign, e1 (11-bit signed), mant[22:0], guard, sticky, zero.
  - prod[47]=1: mant=prod[46:24], guard=prod[23], sticky=|prod[22:0], e1=in_exp-126.
  - prod[47]=0, prod[46]=1: mant=prod[45:23], guard=prod[22], sticky=|prod[21:0], e1=in_exp-127.
  - prod[47:46]=0: zero=1.
- **Stage 2, round/pack.** Registers out_valid, out_result, out_ovf, out_unf.
  - round_up = ROUND_EN & guard & (sticky | mant[0]).
  - 24-bit sum {0,mant}+round_up. On carry-out: frac=0, e2=e1+1; otherwise e2=e1.
  - Priority order:
    - zero → {sign,31'b0}, no flags.
    - e2 ≥ 255 → {sign,8'hFF,23'b0}, out_ovf=1.
    - e2 ≤ 0 → {sign,31'b0}, out_unf=1. Denormals are not produced.
    - otherwise → {sign,e2[7:0],frac}.
- All exponent arithmetic is 11-bit signed. No wrap is permitted.
- **Pipeline control.**
  - s2 loads when !out_valid || out_ready.
  - s1 advances into s2 under the same condition.
  - in_ready = !s1_valid || (!out_valid || out_ready). Combinational, no path from in_valid.
  - A stalled stage holds all fields unchanged.
  - Simultaneous drain and fill of a stage in one cycle is legal. Throughput is 1 result/cycle.
- **NaN/Inf inputs.** Not handled here. Special cases are resolved upstream.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert expected):
  - s1_valid=0, out_valid=0, out_result=0, out_ovf=0, out_unf=0, all datapath registers 0.
  - in_ready=1 immediately after reset asserts.
- Reset mid-operation discards all in-flight items. No result for them is ever presented.
- Latency with out_ready held 1:
  - accept on edge N → out_valid=1 with the result after edge N+1.
  - That is, visible in cycle N+1 and consumed at edge N+2.
- Backpressure:
  - out_ready=0 with out_valid=1 holds out_result and flags stable.
  - While out_ready=0, one more item may enter s1. After that, in_ready=0.
  - Deasserting out_ready never loses or duplicates items. Output order equals input order.
- Flags are meaningful only when out_valid=1.

## Test plan
1. **Basic products** (1.0×1.0, then 1.5×1.5). Stimulus: in_exp=254 with prod=0x400000000000, then prod=0xC00000×0xC00000=0x900000000000, sign=0, out_ready=1. Response: 0x3F800000, then 0x40100000, each 2 cycles after acceptance, no flags.
2. **Round to nearest even.** Stimulus, in_exp=254:
   - prod=0x400000400000 (tie, lsb 0) → 0x3F800000.
   - prod=0x400000C00000 (tie, lsb 1) → 0x3F800002.
   - prod=0x7FFFFFC00000 (round carry) → 0x40000000.
   - Repeat with ROUND_EN=0 → 0x3F800000, 0x3F800001, 0x3FFFFFFF.
3. **Overflow, underflow, zero.**
   - in_exp=400, prod=0x400000000000 → 0x7F800000, out_ovf=1.
   - sign=1, in_exp=100 → 0x80000000, out_unf=1.
   - prod=0 → signed zero, no flags.
   - in_exp=381, prod[47]=1 (e=255) → ovf.
   - in_exp=128, prod[46]=1 (e=1) → normal 0x00800000.
4. **Backpressure.** Stream 8 distinct items back-to-back while out_ready toggles in a pseudo-random pattern. Response: in_ready drops after two items are buffered; all 8 results emerge in order; out_result is stable during every stall.
5. **Reset mid-stream.** Assert reset low with both stages valid. Response: out_valid=0 and outputs 0 immediately; after release, a new item yields a correct result with no residual items.
6. **Full throughput.** Stream 16 items with in_valid=1 and out_ready=1. Response: 16 consecutive out_valid cycles and in_ready constantly 1.

Source files
------------

// File: rtl/fp_norm_round_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_round_if
// Description : Input/output handshake bundle for the multiplier back end.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_norm_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exp;
    logic [47:0] in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;

    modport master (
        output in_valid, in_sign, in_exp, in_prod, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf
    );
endinterface
`default_nettype wire

// File: rtl/fp_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_round
// Description : Two-stage normalize / round-and-pack back end producing
//               binary32 results with overflow and flush-to-zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_round #(
    parameter bit ROUND_EN = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fp_norm_round_if.slave  bus
);

    localparam logic signed [10:0] c_BIAS_HI = 11'sd126;
    localparam logic signed [10:0] c_BIAS_LO = 11'sd127;
    localparam logic signed [10:0] c_EXP_MAX = 11'sd255;
    localparam logic signed [10:0] c_EXP_MIN = 11'sd0;

    logic                r_s1_valid;
    logic                r_s1_sign;
    logic signed [10:0]  r_s1_exp;
    logic [22:0]         r_s1_mant;
    logic                r_s1_guard;
    logic                r_s1_sticky;
    logic                r_s1_zero;

    logic                r_out_valid;
    logic [31:0]         r_out_result;
    logic                r_out_ovf;
    logic                r_out_unf;

    logic                w_s2_load;
    logic                w_s1_load;

    // Stage 2 frees up when empty or draining; stage 1 can then always move on.
    assign w_s2_load    = !r_out_valid || bus.out_ready;
    assign w_s1_load    = !r_s1_valid || w_s2_load;
    assign bus.in_ready = w_s1_load;

    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_ovf    = r_out_ovf;
    assign bus.out_unf    = r_out_unf;

    logic                w_n_zero;
    logic [22:0]         w_n_mant;
    logic                w_n_guard;
    logic                w_n_sticky;
    logic signed [10:0]  w_n_exp;

    always_comb begin
        w_n_zero   = 1'b0;
        w_n_mant   = bus.in_prod[45:23];
        w_n_guard  = bus.in_prod[22];
        w_n_sticky = |bus.in_prod[21:0];
        w_n_exp    = $signed({2'b00, bus.in_exp}) - c_BIAS_LO;
        if (bus.in_prod[47]) begin
            w_n_mant   = bus.in_prod[46:24];
            w_n_guard  = bus.in_prod[23];
            w_n_sticky = |bus.in_prod[22:0];
            w_n_exp    = $signed({2'b00, bus.in_exp}) - c_BIAS_HI;
        end else if (!bus.in_prod[46]) begin
            w_n_zero = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_mant   <= '0;
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_zero   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign   <= bus.in_sign;
                r_s1_exp    <= w_n_exp;
                r_s1_mant   <= w_n_mant;
                r_s1_guard  <= w_n_guard;
                r_s1_sticky <= w_n_sticky;
                r_s1_zero   <= w_n_zero;
            end
        end
    end

    logic                w_round_up;
    logic [23:0]         w_sum;
    logic [22:0]         w_frac;
    logic signed [10:0]  w_e2;
    logic [31:0]         w_result;
    logic                w_ovf;
    logic                w_unf;

    always_comb begin
        w_round_up = ROUND_EN & r_s1_guard & (r_s1_sticky | r_s1_mant[0]);
        w_sum      = {1'b0, r_s1_mant} + {23'd0, w_round_up};
        // A carry out of the mantissa means 1.111..1 rounded to 10.0.
        w_frac     = w_sum[23] ? 23'd0 : w_sum[22:0];
        w_e2       = r_s1_exp + $signed({10'd0, w_sum[23]});
        w_ovf      = 1'b0;
        w_unf      = 1'b0;
        if (r_s1_zero) begin
            w_result = {r_s1_sign, 31'd0};
        end else if (w_e2 >= c_EXP_MAX) begin
            w_result = {r_s1_sign, 8'hFF, 23'd0};
            w_ovf    = 1'b1;
        end else if (w_e2 <= c_EXP_MIN) begin
            w_result = {r_s1_sign, 31'd0};
            w_unf    = 1'b1;
        end else begin
            w_result = {r_s1_sign, w_e2[7:0], w_frac};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_ovf    <= 1'b0;
            r_out_unf    <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result <= w_result;
                r_out_ovf    <= w_ovf;
                r_out_unf    <= w_unf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_norm_round
// Description : Directed bench for fp_norm_round, rounding and truncating builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_norm_round;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fp_norm_round_if bus_r ();
    fp_norm_round_if bus_t ();

    // The truncating build sees exactly the same stimulus as the rounding one.
    assign bus_t.in_valid  = bus_r.in_valid;
    assign bus_t.in_sign   = bus_r.in_sign;
    assign bus_t.in_exp    = bus_r.in_exp;
    assign bus_t.in_prod   = bus_r.in_prod;
    assign bus_t.out_ready = bus_r.out_ready;

    fp_norm_round #(.ROUND_EN(1'b1)) dut_rne (.clk(clk), .reset(reset), .bus(bus_r.slave));
    fp_norm_round #(.ROUND_EN(1'b0)) dut_trn (.clk(clk), .reset(reset), .bus(bus_t.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_k(input int k);
        bus_r.in_sign = k[0];
        bus_r.in_exp  = 9'(251 + k);
        bus_r.in_prod = 48'h4000_0000_0000 | (48'(k + 1) << 23);
    endtask

    function automatic logic [31:0] exp_k(input int k);
        return {k[0], 8'(124 + k), 23'(k + 1)};
    endfunction

    // One item through an empty pipeline with out_ready held high.
    task automatic one(input string tag, input bit s, input bit [8:0] e, input bit [47:0] p,
                       input bit [31:0] rr, input bit rovf, input bit runf,
                       input bit [31:0] tr, input bit tovf, input bit tunf);
        bus_r.in_valid = 1'b1;
        bus_r.in_sign  = s;
        bus_r.in_exp   = e;
        bus_r.in_prod  = p;
        chk({tag, "_in_ready"}, bus_r.in_ready, 1'b1);
        @(posedge clk); #1;
        bus_r.in_valid = 1'b0;
        chk({tag, "_latency"}, bus_r.out_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_valid"},    bus_r.out_valid,  1'b1);
        chk({tag, "_rne_res"},  bus_r.out_result, rr);
        chk({tag, "_rne_ovf"},  bus_r.out_ovf,    rovf);
        chk({tag, "_rne_unf"},  bus_r.out_unf,    runf);
        chk({tag, "_trn_res"},  bus_t.out_result, tr);
        chk({tag, "_trn_ovf"},  bus_t.out_ovf,    tovf);
        chk({tag, "_trn_unf"},  bus_t.out_unf,    tunf);
        @(posedge clk); #1;
        chk({tag, "_drained"},  bus_r.out_valid,  1'b0);
    endtask

    initial begin
        logic [31:0] pat;
        logic [31:0] held;
        bit          hold;
        bit          pre_in;
        bit          pre_out;
        bit          saw_stall;
        bit          gap;
        int          sent;
        int          got;

        reset           = 1'b1;
        bus_r.in_valid  = 1'b0;
        bus_r.in_sign   = 1'b0;
        bus_r.in_exp    = '0;
        bus_r.in_prod   = '0;
        bus_r.out_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready",  bus_r.in_ready,   1'b1);
        chk("rst_valid",     bus_r.out_valid,  1'b0);
        chk("rst_result",    bus_r.out_result, 32'h0);
        chk("rst_flags",     {bus_r.out_ovf, bus_r.out_unf}, 2'b00);
        chk("rst_trn_valid", bus_t.out_valid,  1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;

        // Basic products and rounding (rne result, trunc result)
        one("one_x_one",  0, 254, 48'h4000_0000_0000, 32'h3F80_0000, 0, 0, 32'h3F80_0000, 0, 0);
        one("1p5_sq",     0, 254, 48'h9000_0000_0000, 32'h4010_0000, 0, 0, 32'h4010_0000, 0, 0);
        one("tie_even",   0, 254, 48'h4000_0040_0000, 32'h3F80_0000, 0, 0, 32'h3F80_0000, 0, 0);
        one("tie_odd",    0, 254, 48'h4000_00C0_0000, 32'h3F80_0002, 0, 0, 32'h3F80_0001, 0, 0);
        one("rnd_carry",  0, 254, 48'h7FFF_FFC0_0000, 32'h4000_0000, 0, 0, 32'h3FFF_FFFF, 0, 0);
        one("sticky_up",  0, 254, 48'h4000_0060_0000, 32'h3F80_0001, 0, 0, 32'h3F80_0000, 0, 0);

        // Range boundaries and zero
        one("ovf",        0, 400, 48'h4000_0000_0000, 32'h7F80_0000, 1, 0, 32'h7F80_0000, 1, 0);
        one("unf_neg",    1, 100, 48'h4000_0000_0000, 32'h8000_0000, 0, 1, 32'h8000_0000, 0, 1);
        one("zero_neg",   1, 200, 48'h0,              32'h8000_0000, 0, 0, 32'h8000_0000, 0, 0);
        one("ovf_e255",   0, 381, 48'h8000_0000_0000, 32'h7F80_0000, 1, 0, 32'h7F80_0000, 1, 0);
        one("min_normal", 0, 128, 48'h4000_0000_0000, 32'h0080_0000, 0, 0, 32'h0080_0000, 0, 0);
        one("unf_e0",     0, 127, 48'h4000_0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0000, 0, 1);
        one("rnd_to_ovf", 0, 380, 48'hFFFF_FF80_0000, 32'h7F80_0000, 1, 0, 32'h7F7F_FFFF, 0, 0);
        one("max_exp",    0, 510, 48'h8000_0000_0000, 32'h7F80_0000, 1, 0, 32'h7F80_0000, 1, 0);

        // Backpressure: 8 items against a fixed irregular out_ready pattern
        pat = 32'h96D3_A4C0;
        sent = 0; got = 0; saw_stall = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            bus_r.in_valid = (sent < 8);
            if (sent < 8) drive_k(sent);
            bus_r.out_ready = pat[cyc % 32];
            #1;
            pre_in  = bus_r.in_valid && bus_r.in_ready;
            pre_out = bus_r.out_valid && bus_r.out_ready;
            if (!bus_r.in_ready) begin
                saw_stall = 1'b1;
                chk("bp_inflight", 48'(sent - got), 48'd2);
            end
            hold = bus_r.out_valid && !bus_r.out_ready;
            held = bus_r.out_result;
            if (pre_out) begin
                chk("bp_order", bus_r.out_result, exp_k(got));
                got++;
            end
            @(posedge clk); #1;
            if (pre_in) sent++;
            if (hold) begin
                chk("bp_stable", bus_r.out_result, held);
                chk("bp_hold_valid", bus_r.out_valid, 1'b1);
            end
        end
        bus_r.in_valid  = 1'b0;
        bus_r.out_ready = 1'b1;
        chk("bp_count", 48'(got), 48'd8);
        chk("bp_stalled", saw_stall, 1'b1);
        @(posedge clk); #1;
        chk("bp_empty", bus_r.out_valid, 1'b0);

        // Reset with both stages occupied
        bus_r.out_ready = 1'b0;
        bus_r.in_valid  = 1'b1;
        drive_k(0);
        @(posedge clk); #1;
        drive_k(1);
        @(posedge clk); #1;
        bus_r.in_valid = 1'b0;
        chk("rm_full_valid", bus_r.out_valid, 1'b1);
        chk("rm_full_ready", bus_r.in_ready,  1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rm_valid",    bus_r.out_valid,  1'b0);
        chk("rm_result",   bus_r.out_result, 32'h0);
        chk("rm_flags",    {bus_r.out_ovf, bus_r.out_unf}, 2'b00);
        chk("rm_in_ready", bus_r.in_ready,   1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_r.out_ready = 1'b1;
        one("rm_after", 0, 254, 48'h9000_0000_0000, 32'h4010_0000, 0, 0, 32'h4010_0000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rm_residual", bus_r.out_valid, 1'b0);
        end

        // Full throughput: 16 items back to back
        sent = 0; got = 0; gap = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            bus_r.in_valid = (sent < 16);
            if (sent < 16) drive_k(sent);
            #1;
            pre_in = bus_r.in_valid && bus_r.in_ready;
            if (sent < 16) chk("ft_in_ready", bus_r.in_ready, 1'b1);
            if (bus_r.out_valid) begin
                chk("ft_result", bus_r.out_result, exp_k(got));
                got++;
            end else if (got > 0) begin
                gap = 1'b1;
            end
            @(posedge clk); #1;
            if (pre_in) sent++;
        end
        bus_r.in_valid = 1'b0;
        chk("ft_count", 48'(got), 48'd16);
        chk("ft_no_gap", gap, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
